// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings and the error-handling FSM state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] HSIZE_BYTE = 2'd0;
  localparam logic [1:0] HSIZE_HALF = 2'd1;
  localparam logic [1:0] HSIZE_WORD = 2'd2;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // OKAY: normal operation; ERR1: first cycle of a two-cycle ERROR response;
  // ERR2: one-cycle recovery after the erroring transfer has completed.
  typedef enum logic [1:0] {
    OKAY,
    ERR1,
    ERR2
  } fsm_state_e;

endpackage

// File: rtl/ahb_lane_align.sv
// Byte-lane alignment for the 32-bit AHB data bus (purely combinational).
//   i_extract : 0 = write path (replicate), 1 = read path (extract + zero-extend)
//   i_size    : transfer size (byte/half/word; anything else passes data through)
//   i_addr_lo : address bits [1:0], selects the lane when extracting
//   i_data    : write data (right-justified) or raw hrdata
//   o_data    : replicated write data or extracted read data
module ahb_lane_align
  import ahb_pkg::*;
(
  input  logic        i_extract,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    // Replication always uses the low bits; extraction picks the addressed lane.
    w_byte = i_data[7:0];
    w_half = i_data[15:0];
    if (i_extract) begin
      case (i_addr_lo)
        2'd0:    w_byte = i_data[7:0];
        2'd1:    w_byte = i_data[15:8];
        2'd2:    w_byte = i_data[23:16];
        default: w_byte = i_data[31:24];
      endcase
      w_half = i_addr_lo[1] ? i_data[31:16] : i_data[15:0];
    end

    case (i_size)
      HSIZE_BYTE: o_data = i_extract ? {24'h0, w_byte} : {4{w_byte}};
      HSIZE_HALF: o_data = i_extract ? {16'h0, w_half} : {2{w_half}};
      HSIZE_WORD: o_data = i_data;
      default:    o_data = i_data;
    endcase
  end

endmodule

// File: rtl/ahb_lite_master.sv
// AHB-lite single-transfer master with a pipelined command/response interface.
// Commands are issued as single NONSEQ transfers; one response pulse is returned
// per accepted command, in order, the cycle after its data phase completes.
//   clk, n_rst         : clock, asynchronous active-low reset
//   cmd_*              : command handshake (valid/ready) and transfer attributes
//   rsp_*              : one-cycle completion pulse with read data and error flag
//   h*                 : AHB-lite master signals (address phase outputs registered)
module ahb_lite_master
  import ahb_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [6:0]  cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        hsel,
  output logic [6:0]  haddr,
  output logic [1:0]  htrans,
  output logic [1:0]  hsize,
  output logic        hwrite,
  output logic [2:0]  hburst,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);

  fsm_state_e  r_state;
  // Address-phase registers
  logic [1:0]  r_htrans;
  logic [6:0]  r_haddr;
  logic [1:0]  r_hsize;
  logic        r_hwrite;
  logic [31:0] r_wdata;
  // Data-phase registers
  logic        r_dp_valid;
  logic        r_dp_write;
  logic [1:0]  r_dp_addr;
  logic [1:0]  r_dp_size;
  logic [31:0] r_hwdata;
  // Set when entering ERR1 with an address phase pending; that transfer owes an error response
  logic        r_cancel;
  // Response registers
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_error;

  logic        w_in_err1;
  logic        w_addr_nonseq;
  logic        w_dp_done;
  logic        w_err_wait;
  logic        w_err_done;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_rdata_ext;

  assign w_in_err1     = (r_state == ERR1);
  assign w_addr_nonseq = (r_htrans == HTRANS_NONSEQ);
  assign w_dp_done     = r_dp_valid && hready;
  // First cycle of an ERROR response (hready low) vs. a one-cycle ERROR (protocol violation)
  assign w_err_wait    = !w_in_err1 && r_dp_valid && hresp && !hready;
  assign w_err_done    = !w_in_err1 && r_dp_valid && hresp && hready;

  assign cmd_ready = n_rst && hready && !w_in_err1;

  assign hsel      = w_addr_nonseq;
  assign haddr     = r_haddr;
  assign htrans    = r_htrans;
  assign hsize     = r_hsize;
  assign hwrite    = r_hwrite;
  assign hburst    = HBURST_SINGLE;
  assign hwdata    = r_hwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_error = r_rsp_error;

  ahb_lane_align u_wr_align (
    .i_extract (1'b0),
    .i_size    (r_hsize),
    .i_addr_lo (r_haddr[1:0]),
    .i_data    (r_wdata),
    .o_data    (w_wdata_rep)
  );

  ahb_lane_align u_rd_align (
    .i_extract (1'b1),
    .i_size    (r_dp_size),
    .i_addr_lo (r_dp_addr),
    .i_data    (hrdata),
    .o_data    (w_rdata_ext)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= OKAY;
      r_htrans    <= HTRANS_IDLE;
      r_haddr     <= '0;
      r_hsize     <= '0;
      r_hwrite    <= 1'b0;
      r_wdata     <= '0;
      r_dp_valid  <= 1'b0;
      r_dp_write  <= 1'b0;
      r_dp_addr   <= '0;
      r_dp_size   <= '0;
      r_hwdata    <= '0;
      r_cancel    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      // FSM
      case (r_state)
        ERR1: begin
          if (hready) r_state <= ERR2;
        end
        default: begin
          if (w_err_wait) begin
            r_state <= ERR1;
          end else if (w_err_done) begin
            r_state <= ERR2;
          end else begin
            r_state <= OKAY;
          end
        end
      endcase

      if (w_err_wait) begin
        r_cancel <= w_addr_nonseq;
      end else if (r_state == ERR2) begin
        r_cancel <= 1'b0;
      end

      // Response: data-phase completion, or the deferred error for a cancelled transfer
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_rdata <= '0;
      if (w_dp_done) begin
        r_rsp_valid <= 1'b1;
        if (hresp || w_in_err1) begin
          r_rsp_error <= 1'b1;
        end else if (!r_dp_write) begin
          r_rsp_rdata <= w_rdata_ext;
        end
      end else if ((r_state == ERR2) && r_cancel) begin
        r_rsp_valid <= 1'b1;
        r_rsp_error <= 1'b1;
      end

      // Pipeline: an ERROR's first cycle kills the pending address phase even though
      // hready is low; otherwise everything moves only on hready.
      if (w_err_wait) begin
        r_htrans <= HTRANS_IDLE;
      end else if (hready) begin
        r_dp_valid <= w_addr_nonseq;
        if (w_addr_nonseq) begin
          r_dp_write <= r_hwrite;
          r_dp_addr  <= r_haddr[1:0];
          r_dp_size  <= r_hsize;
          r_hwdata   <= w_wdata_rep;
        end
        if (!w_in_err1) begin
          if (cmd_valid) begin
            r_htrans <= HTRANS_NONSEQ;
            r_haddr  <= cmd_addr;
            r_hsize  <= cmd_size;
            r_hwrite <= cmd_write;
            r_wdata  <= cmd_wdata;
          end else begin
            r_htrans <= HTRANS_IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Self-checking bench for ahb_lite_master: directed scenarios followed by
// randomized traffic checked against a transaction-queue reference model.
module tb_ahb_lite_master;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [6:0]  cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        hsel;
  logic [6:0]  haddr;
  logic [1:0]  htrans;
  logic [1:0]  hsize;
  logic        hwrite;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ahb_lite_master dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hsize     (hsize),
    .hwrite    (hwrite),
    .hburst    (hburst),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .hready    (hready),
    .hresp     (hresp)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_cmd(input logic v, input logic w, input logic [6:0] a,
                           input logic [1:0] s, input logic [31:0] d);
    cmd_valid = v;
    cmd_write = w;
    cmd_addr  = a;
    cmd_size  = s;
    cmd_wdata = d;
  endtask

  // Step negedges until rsp_valid is seen; lat is the cycle count since acceptance, or -1.
  task automatic wait_rsp(input int start, input int max, output int lat);
    lat = -1;
    for (int k = start + 1; k <= max; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  // Reference lane behaviour expressed arithmetically.
  function automatic logic [31:0] exp_rep(input logic [1:0] s, input logic [31:0] d);
    case (s)
      2'd0:    return {24'h0, d[7:0]} * 32'h0101_0101;
      2'd1:    return {16'h0, d[15:0]} * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_ext(input logic [1:0] s, input logic [6:0] a,
                                          input logic [31:0] d);
    int sh;
    case (s)
      2'd0: begin
        sh = 8 * int'(a[1:0]);
        return (d >> sh) & 32'h0000_00FF;
      end
      2'd1: begin
        sh = 16 * int'(a[1]);
        return (d >> sh) & 32'h0000_FFFF;
      end
      default: return d;
    endcase
  endfunction

  typedef struct packed {
    logic        write;
    logic [6:0]  addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [1:0]  hops;   // hready edges left: 2 = address phase, 1 = data phase
  } txn_t;

  txn_t        pend[$];
  txn_t        t;
  logic        p_valid, p_write, p_hready;
  logic [6:0]  p_addr;
  logic [1:0]  p_size;
  logic [31:0] p_wdata, p_hrdata;
  logic        exp_v;
  logic [31:0] exp_d;
  int          ai, di, lat, n_rsp;
  logic [6:0]  a3 [4];
  logic [31:0] d3 [4];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    n_rst  = 1'b0;
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    drive_cmd(1'b0, 1'b0, 7'h0, 2'd0, 32'h0);

    // Reset state
    @(negedge clk);
    check_eq("rst_htrans", 32'(htrans), 32'd0);
    check_eq("rst_hsel", 32'(hsel), 32'd0);
    check_eq("rst_ready", 32'(cmd_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_hwdata", hwdata, 32'h0);
    @(negedge clk);
    n_rst = 1'b1;

    // Zero-wait word read
    @(negedge clk);
    hrdata = 32'hDEAD_BEEF;
    drive_cmd(1'b1, 1'b0, 7'h04, 2'd2, 32'h0);
    #1 check_eq("t1_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    check_eq("t1_htrans", 32'(htrans), 32'd2);
    check_eq("t1_hsel", 32'(hsel), 32'd1);
    check_eq("t1_haddr", 32'(haddr), 32'h04);
    check_eq("t1_hwrite", 32'(hwrite), 32'd0);
    check_eq("t1_hburst", 32'(hburst), 32'd0);
    drive_cmd(1'b0, 1'b0, 7'h0, 2'd0, 32'h0);
    wait_rsp(1, 10, lat);
    check_eq("t1_lat", 32'(lat), 32'd3);
    check_eq("t1_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check_eq("t1_err", 32'(rsp_error), 32'd0);
    @(negedge clk);
    check_eq("t1_pulse", 32'(rsp_valid), 32'd0);

    // Byte write with two wait states
    drive_cmd(1'b1, 1'b1, 7'h13, 2'd0, 32'h0000_00A5);
    #1 check_eq("t2_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    check_eq("t2_haddr", 32'(haddr), 32'h13);
    check_eq("t2_hsize", 32'(hsize), 32'd0);
    check_eq("t2_hwrite", 32'(hwrite), 32'd1);
    drive_cmd(1'b0, 1'b0, 7'h0, 2'd0, 32'h0);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      check_eq("t2_hwdata", hwdata, 32'hA5A5_A5A5);
      check_eq("t2_no_rsp", 32'(rsp_valid), 32'd0);
      hready = (i == 4);
    end
    wait_rsp(4, 10, lat);
    hready = 1'b1;
    check_eq("t2_lat", 32'(lat), 32'd5);
    check_eq("t2_err", 32'(rsp_error), 32'd0);

    // Back-to-back word writes
    a3 = '{7'h20, 7'h24, 7'h28, 7'h2C};
    d3 = '{32'h0102_0304, 32'hA0B0_C0D0, 32'h5555_AAAA, 32'hFFFF_0001};
    n_rsp = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 1 && i <= 4) begin
        check_eq("t3_htrans", 32'(htrans), 32'd2);
        check_eq("t3_haddr", 32'(haddr), 32'(a3[i-1]));
      end else begin
        check_eq("t3_idle", 32'(htrans), 32'd0);
      end
      if (i >= 2 && i <= 5) check_eq("t3_hwdata", hwdata, d3[i-2]);
      check_eq("t3_rsp", 32'(rsp_valid), 32'((i >= 3) && (i <= 6)));
      if (rsp_valid) n_rsp++;
      if (i < 4) begin
        drive_cmd(1'b1, 1'b1, a3[i], 2'd2, d3[i]);
        #1 check_eq("t3_ready", 32'(cmd_ready), 32'd1);
      end else begin
        drive_cmd(1'b0, 1'b0, 7'h0, 2'd0, 32'h0);
      end
    end
    check_eq("t3_nrsp", 32'(n_rsp), 32'd4);

    // Error with cancellation of the queued read
    drive_cmd(1'b1, 1'b1, 7'h08, 2'd2, 32'h1122_3344);
    #1 check_eq("t4_ready_a", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    check_eq("t4_haddr_a", 32'(haddr), 32'h08);
    drive_cmd(1'b1, 1'b0, 7'h0C, 2'd2, 32'h0);
    #1 check_eq("t4_ready_b", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    check_eq("t4_haddr_b", 32'(haddr), 32'h0C);
    drive_cmd(1'b0, 1'b0, 7'h0, 2'd0, 32'h0);
    hready = 1'b0;
    hresp  = 1'b1;
    @(negedge clk);
    check_eq("t4_err1_htrans", 32'(htrans), 32'd0);
    check_eq("t4_err1_hsel", 32'(hsel), 32'd0);
    check_eq("t4_err1_rsp", 32'(rsp_valid), 32'd0);
    hready = 1'b1;
    #1 check_eq("t4_err1_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    hresp = 1'b0;
    check_eq("t4_rsp_a", 32'(rsp_valid), 32'd1);
    check_eq("t4_err_a", 32'(rsp_error), 32'd1);
    check_eq("t4_idle_a", 32'(htrans), 32'd0);
    @(negedge clk);
    check_eq("t4_rsp_b", 32'(rsp_valid), 32'd1);
    check_eq("t4_err_b", 32'(rsp_error), 32'd1);
    check_eq("t4_idle_b", 32'(htrans), 32'd0);
    @(negedge clk);
    check_eq("t4_rsp_end", 32'(rsp_valid), 32'd0);
    check_eq("t4_idle_end", 32'(htrans), 32'd0);

    // Half-word read from the upper half
    hrdata = 32'h1234_5678;
    drive_cmd(1'b1, 1'b0, 7'h0E, 2'd1, 32'h0);
    @(negedge clk);
    check_eq("t5_hsize", 32'(hsize), 32'd1);
    drive_cmd(1'b0, 1'b0, 7'h0, 2'd0, 32'h0);
    wait_rsp(1, 10, lat);
    check_eq("t5_lat", 32'(lat), 32'd3);
    check_eq("t5_rdata", rsp_rdata, 32'h0000_1234);

    // Reset while a write is in its data phase and a read is in its address phase
    @(negedge clk);
    drive_cmd(1'b1, 1'b1, 7'h10, 2'd2, 32'hCAFE_F00D);
    @(negedge clk);
    drive_cmd(1'b1, 1'b0, 7'h14, 2'd2, 32'h0);
    @(negedge clk);
    drive_cmd(1'b0, 1'b0, 7'h0, 2'd0, 32'h0);
    hready = 1'b0;
    check_eq("t6_hwdata_pre", hwdata, 32'hCAFE_F00D);
    #2 n_rst = 1'b0;
    #1;
    check_eq("t6_htrans", 32'(htrans), 32'd0);
    check_eq("t6_hsel", 32'(hsel), 32'd0);
    check_eq("t6_haddr", 32'(haddr), 32'd0);
    check_eq("t6_hsize", 32'(hsize), 32'd0);
    check_eq("t6_hwrite", 32'(hwrite), 32'd0);
    check_eq("t6_hwdata", hwdata, 32'h0);
    check_eq("t6_rsp", {rsp_rdata[30:0], rsp_valid} | 32'(rsp_error), 32'h0);
    check_eq("t6_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    n_rst  = 1'b1;
    hready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("t6_no_rsp", 32'(rsp_valid), 32'd0);
      check_eq("t6_idle", 32'(htrans), 32'd0);
    end

    // Randomized traffic against the queue model (no errors)
    p_valid  = 1'b0;
    p_write  = 1'b0;
    p_addr   = '0;
    p_size   = '0;
    p_wdata  = '0;
    p_hready = 1'b1;
    p_hrdata = hrdata;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      exp_v = 1'b0;
      exp_d = '0;
      if (p_hready) begin
        if (pend.size() > 0 && pend[0].hops == 2'd1) begin
          exp_v = 1'b1;
          exp_d = pend[0].write ? 32'h0 : exp_ext(pend[0].size, pend[0].addr, p_hrdata);
          void'(pend.pop_front());
        end
        foreach (pend[i]) pend[i].hops = pend[i].hops - 2'd1;
        if (p_valid) begin
          t = '{write: p_write, addr: p_addr, size: p_size, wdata: p_wdata, hops: 2'd2};
          pend.push_back(t);
        end
      end
      ai = -1;
      di = -1;
      foreach (pend[i]) begin
        if (pend[i].hops == 2'd2) ai = i;
        if (pend[i].hops == 2'd1) di = i;
      end
      if (ai >= 0) begin
        check_eq("rnd_htrans", 32'(htrans), 32'd2);
        check_eq("rnd_hsel", 32'(hsel), 32'd1);
        check_eq("rnd_haddr", 32'(haddr), 32'(pend[ai].addr));
        check_eq("rnd_hsize", 32'(hsize), 32'(pend[ai].size));
        check_eq("rnd_hwrite", 32'(hwrite), 32'(pend[ai].write));
      end else begin
        check_eq("rnd_idle", 32'(htrans), 32'd0);
        check_eq("rnd_hsel_idle", 32'(hsel), 32'd0);
      end
      if (di >= 0 && pend[di].write) begin
        check_eq("rnd_hwdata", hwdata, exp_rep(pend[di].size, pend[di].wdata));
      end
      check_eq("rnd_hburst", 32'(hburst), 32'd0);
      check_eq("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (exp_v) begin
        check_eq("rnd_rdata", rsp_rdata, exp_d);
        check_eq("rnd_err", 32'(rsp_error), 32'd0);
      end
      drive_cmd(($urandom_range(0, 99) < 70), 1'($urandom_range(0, 1)),
                7'($urandom_range(0, 127)), 2'($urandom_range(0, 2)), $urandom);
      hready = ($urandom_range(0, 99) < 75);
      hrdata = $urandom;
      #1 check_eq("rnd_ready", 32'(cmd_ready), 32'(hready));
      p_valid  = cmd_valid;
      p_write  = cmd_write;
      p_addr   = cmd_addr;
      p_size   = cmd_size;
      p_wdata  = cmd_wdata;
      p_hready = hready;
      p_hrdata = hrdata;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master.md
AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous active-low reset, with ports listed as follows.
- clk  in  1  rising-edge clock.
- n_rst  in  1  asynchronous active-low reset.
REQ-002 The block SHALL have the following command ports:
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  7  byte address.
- cmd_size  in  2  0 = byte, 1 = half, 2 = word.
- cmd_wdata  in  32  write data, right-justified.
REQ-003 The block SHALL have the following response ports:
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  read data, lane-extracted, zero-extended.
- rsp_error  out  1  transfer failed or was cancelled.
REQ-004 The block SHALL have the following AHB-lite ports:
- hsel, haddr[6:0], htrans[1:0], hsize[1:0], hwrite, hburst[2:0], hwdata[31:0]  out.
- hrdata[31:0], hready, hresp  in.

Function
REQ-005 The block SHALL drive only single NONSEQ transfers: hburst = 3'b000 and htrans ∈ {IDLE, NONSEQ}.
REQ-006 The block SHALL drive hsel = 1 exactly when htrans = NONSEQ.
REQ-007 The block SHALL drive all address-phase outputs from registers; no combinational path from cmd_* to h* outputs.
REQ-008 The block SHALL compute cmd_ready = hready AND state ≠ ERR1.
- On an edge with cmd_valid & cmd_ready, the command SHALL load into the address-phase registers.
- On an edge with cmd_ready high and no valid command, htrans SHALL become IDLE.
REQ-009 The block SHALL advance the address-phase transfer into the data phase on every edge where hready = 1, and SHALL hold all h* outputs while hready = 0.
REQ-010 The block SHALL sustain back-to-back commands at one transfer per cycle against a zero-wait slave.
REQ-011 The block SHALL drive hwdata from the data-phase registers, stable for the entire data phase including wait states, with lane placement:
- byte: cmd_wdata[7:0] replicated to all four lanes.
- half: cmd_wdata[15:0] replicated to both halves.
- word: cmd_wdata unchanged.
REQ-012 The block SHALL extract read data at data-phase completion as follows:
- byte: hrdata lane addr[1:0].
- half: hrdata half addr[1].
- The result SHALL be zero-extended into rsp_rdata.
REQ-013 The block SHALL pulse rsp_valid on the cycle after the data-phase completion edge.
- rsp_rdata and rsp_error SHALL be valid only while rsp_valid = 1.
- Responses SHALL occur in command order.
REQ-014 The block SHALL have a response latency from command acceptance of exactly 3 cycles with a zero-wait slave, extended by one cycle per wait state.
REQ-015 The block SHALL implement the FSM states OKAY, ERR1 and ERR2.
- On hresp = 1 with hready = 0 in OKAY, the next state SHALL be ERR1.
- While in ERR1, the block SHALL force htrans = IDLE, cancelling any pending address phase.
- On hresp = 1 with hready = 1, the next state SHALL be ERR2.
- ERR2 SHALL return to OKAY after one cycle.
REQ-016 On error, the erroring transfer SHALL respond with rsp_error = 1, and the transfer cancelled in ERR1 (if any) SHALL respond with rsp_error = 1 on the following cycle.
REQ-017 The block SHALL pass cmd_size = 3 and misaligned addresses to the bus unmodified; the slave reports the error.
REQ-018 The block SHALL treat hresp = 1 with hready = 1 seen in OKAY as a protocol violation: it SHALL complete the transfer with rsp_error = 1 and SHALL NOT enter ERR1.

Reset
REQ-019 While n_rst = 0, the following SHALL hold immediately and asynchronously:
- htrans = IDLE, hsel = 0, haddr = 0, hsize = 0, hwrite = 0, hwdata = 0.
- rsp_valid = 0, rsp_rdata = 0, rsp_error = 0.
- FSM = OKAY.
- All pending transfers discarded.
REQ-020 The block SHALL drive cmd_ready = 0 during reset, and SHALL NOT generate a response for any transfer in flight when reset asserts.

Structure
REQ-021 Package ahb_pkg SHALL hold the following shared definitions:
- HTRANS_IDLE = 2'b00, HTRANS_NONSEQ = 2'b10.
- HSIZE_BYTE/HALF/WORD.
- HBURST_SINGLE = 3'b000.
- FSM enum {OKAY, ERR1, ERR2}.
REQ-022 Lane replication and extraction SHALL be a combinational sub-module ahb_lane_align, instantiated twice (write path and read path).

Verification
REQ-023 Zero-wait read: cmd read addr 7'h04 word with hrdata = 32'hDEADBEEF → rsp_valid 3 cycles after acceptance, rsp_rdata = 32'hDEADBEEF, rsp_error = 0.
REQ-024 Byte write with two wait states: addr 7'h13, cmd_wdata = 32'h000000A5, hready low 2 cycles → hwdata = 32'hA5A5A5A5 held 3 cycles, rsp_valid 5 cycles after acceptance.
REQ-025 Back-to-back: 4 word writes on consecutive cycles to zero-wait slave → htrans NONSEQ on 4 consecutive cycles, cmd_ready constantly 1, 4 rsp_valid pulses in order.
REQ-026 Error cancel: write A then read B back-to-back, slave returns two-cycle ERROR on A → htrans IDLE during ERR1, B never driven, two responses, both rsp_error = 1.
REQ-027 Half-word read addr 7'h0E, hrdata = 32'h12345678 → rsp_rdata = 32'h00001234; reset asserted mid-data-phase → outputs idle immediately, no rsp_valid afterwards.
